// File: rtl/p_wqe_pkg.sv
// -----------------------------------------------------------------------------
// p_wqe_pkg
// Shared constants for the WQE ring controller and its output buffer.
//   MEM_RD_LAT : read latency of the dual-port WQE SRAM (address -> data)
//   OB_DEPTH   : number of entries in the output buffer in front of rd_*
//   OB_CNT_W   : width of an output-buffer occupancy count (0..OB_DEPTH)
// -----------------------------------------------------------------------------
package p_wqe_pkg;

    localparam int unsigned MEM_RD_LAT = 1;
    localparam int unsigned OB_DEPTH   = 2;
    localparam int unsigned OB_CNT_W   = $clog2(OB_DEPTH + 1);

    typedef logic [OB_CNT_W-1:0] ob_cnt_t;

endpackage

// File: rtl/p_wqe_ob.sv
// -----------------------------------------------------------------------------
// p_wqe_ob
// Two-entry output FIFO that sits between the SRAM read port and the consumer.
// Simultaneous push and pop leave the occupancy unchanged.
//
// Ports
//   i_clk        clock
//   i_rst        synchronous active-high reset (empties the buffer)
//   i_clr        synchronous clear, same effect as reset, overrides push/pop
//   i_push       write i_push_data into the buffer
//   i_push_data  word to store
//   i_pop        remove the head entry (ignored when empty)
//   o_vld        buffer holds at least one word
//   o_head       oldest word in the buffer
//   o_cnt        current occupancy
//   o_cnt_nxt    occupancy after this clock edge (clear applied, reset not)
// -----------------------------------------------------------------------------
module p_wqe_ob
    import p_wqe_pkg::*;
#(
    parameter int unsigned WIDTH_DATA = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    input  logic                  i_push,
    input  logic [WIDTH_DATA-1:0] i_push_data,
    input  logic                  i_pop,
    output logic                  o_vld,
    output logic [WIDTH_DATA-1:0] o_head,
    output logic [OB_CNT_W-1:0]   o_cnt,
    output logic [OB_CNT_W-1:0]   o_cnt_nxt
);

    localparam logic [OB_CNT_W-1:0] CNT_FULL = OB_CNT_W'(OB_DEPTH);

    logic [WIDTH_DATA-1:0] r_head;
    logic [WIDTH_DATA-1:0] r_tail;
    logic [OB_CNT_W-1:0]   r_cnt;
    logic [OB_CNT_W-1:0]   w_cnt_nxt;
    logic [OB_CNT_W-1:0]   w_slot;
    logic                  w_pop;
    logic                  w_push;

    assign w_pop  = i_pop && (r_cnt != '0);
    // A full buffer can still accept a word if the head leaves in the same cycle.
    assign w_push = i_push && ((r_cnt != CNT_FULL) || w_pop);
    // Slot index the pushed word lands in, after any shift caused by a pop.
    assign w_slot = r_cnt - OB_CNT_W'(w_pop);

    always_comb begin
        w_cnt_nxt = r_cnt + OB_CNT_W'(w_push) - OB_CNT_W'(w_pop);
        if (i_clr) begin
            w_cnt_nxt = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Head/tail shift structure: a pop moves the tail into the head slot, a
    // push fills whichever slot is first free after that shift.
    always_ff @(posedge i_clk) begin
        if (w_push && (w_slot == '0)) begin
            r_head <= i_push_data;
        end else if (w_pop) begin
            r_head <= r_tail;
        end
        if (w_push && (w_slot == OB_CNT_W'(1))) begin
            r_tail <= i_push_data;
        end
    end

    assign o_vld     = (r_cnt != '0);
    assign o_head    = r_head;
    assign o_cnt     = r_cnt;
    assign o_cnt_nxt = w_cnt_nxt;

endmodule

// File: rtl/p_wqe_ring_ctrl.sv
// -----------------------------------------------------------------------------
// p_wqe_ring_ctrl
// Ring-buffer controller for the WQE queue. Words are written into an external
// dual-port SRAM (port a) and read back through port b into a two-entry output
// buffer that drives the consumer interface. Sustains one word per cycle with
// a write-to-rd_vld latency of three cycles into an empty ring.
//
// Ports
//   clk        sole clock
//   rst        synchronous active-high reset (pointers, buffer, count cleared)
//   flush      synchronous ring clear, priority over write/read/pop
//   wr_vld     producer word valid
//   wr_data    producer word
//   wr_rdy     producer may write
//   rd_vld     consumer word valid
//   rd_data    consumer word (stable while rd_vld && !rd_rdy)
//   rd_rdy     consumer accepts
//   count      words held in total (SRAM + in flight + output buffer)
//   mem_addra  SRAM write address
//   mem_dina   SRAM write data
//   mem_wena   SRAM write enable
//   mem_addrb  SRAM read address
//   mem_renb   SRAM read enable
//   mem_doutb  SRAM read data, valid the cycle after mem_renb
// -----------------------------------------------------------------------------
module p_wqe_ring_ctrl
    import p_wqe_pkg::*;
#(
    parameter int unsigned WIDTH_ADDR = 8,
    parameter int unsigned WIDTH_DATA = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_vld,
    input  logic [WIDTH_DATA-1:0] wr_data,
    output logic                  wr_rdy,
    output logic                  rd_vld,
    output logic [WIDTH_DATA-1:0] rd_data,
    input  logic                  rd_rdy,
    output logic [WIDTH_ADDR+1:0] count,
    output logic [WIDTH_ADDR-1:0] mem_addra,
    output logic [WIDTH_DATA-1:0] mem_dina,
    output logic                  mem_wena,
    output logic [WIDTH_ADDR-1:0] mem_addrb,
    output logic                  mem_renb,
    input  logic [WIDTH_DATA-1:0] mem_doutb
);

    localparam int unsigned PTR_W  = WIDTH_ADDR + 1;
    localparam int unsigned CNT_W  = WIDTH_ADDR + 2;
    localparam int unsigned LOAD_W = OB_CNT_W + 1;

    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic                r_inflight;
    logic [CNT_W-1:0]    r_count;

    logic [PTR_W-1:0]    w_mem_cnt;
    logic [PTR_W-1:0]    w_wr_ptr_nxt;
    logic [PTR_W-1:0]    w_rd_ptr_nxt;
    logic [PTR_W-1:0]    w_mem_cnt_nxt;
    logic [CNT_W-1:0]    w_count_nxt;
    logic                w_full;
    logic                w_clear;
    logic                w_wr_fire;
    logic                w_pop;
    logic                w_rd_issue;
    logic                w_ob_vld;
    logic [WIDTH_DATA-1:0] w_ob_head;
    logic [OB_CNT_W-1:0] w_ob_cnt;
    logic [OB_CNT_W-1:0] w_ob_cnt_nxt;
    logic [LOAD_W-1:0]   w_ob_load;

    assign w_clear   = rst || flush;

    // Occupancy from registered pointers only, so a read can never target the
    // slot being written in the same cycle.
    assign w_mem_cnt = r_wr_ptr - r_rd_ptr;
    // mem_cnt never exceeds 2^WIDTH_ADDR, so its MSB alone marks "full".
    assign w_full    = w_mem_cnt[WIDTH_ADDR];

    // Producer side
    assign wr_rdy    = !w_full && !w_clear;
    assign w_wr_fire = wr_vld && wr_rdy;
    assign mem_wena  = w_wr_fire;
    assign mem_addra = r_wr_ptr[WIDTH_ADDR-1:0];
    assign mem_dina  = wr_data;

    // Consumer side
    assign rd_vld  = w_ob_vld && !rst;
    assign rd_data = w_ob_head;
    assign w_pop   = rd_vld && rd_rdy;

    // Buffer slots already spoken for after this cycle's pop; a new read is
    // only issued when its word is guaranteed a free slot on arrival.
    assign w_ob_load  = LOAD_W'(w_ob_cnt) + LOAD_W'(r_inflight) - LOAD_W'(w_pop);
    assign w_rd_issue = (w_mem_cnt != '0) && !w_clear &&
                        (w_ob_load < LOAD_W'(OB_DEPTH));
    assign mem_renb   = w_rd_issue;
    assign mem_addrb  = r_rd_ptr[WIDTH_ADDR-1:0];

    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_wr_fire);
        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_rd_issue);
        if (flush) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
        end
    end

    // Difference taken at pointer width first so it wraps modulo 2^PTR_W.
    assign w_mem_cnt_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
    assign w_count_nxt   = CNT_W'(w_mem_cnt_nxt) + CNT_W'(w_rd_issue) +
                           CNT_W'(w_ob_cnt_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
            r_count    <= '0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_inflight <= w_rd_issue;
            r_count    <= w_count_nxt;
        end
    end

    assign count = r_count;

    // The in-flight SRAM word lands in the buffer one cycle after issue; a
    // flush in that cycle clears the buffer and so drops the word.
    p_wqe_ob #(
        .WIDTH_DATA (WIDTH_DATA)
    ) u_ob (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_clr       (flush),
        .i_push      (r_inflight),
        .i_push_data (mem_doutb),
        .i_pop       (w_pop),
        .o_vld       (w_ob_vld),
        .o_head      (w_ob_head),
        .o_cnt       (w_ob_cnt),
        .o_cnt_nxt   (w_ob_cnt_nxt)
    );

endmodule

// File: tb/tb_p_wqe_ring_ctrl.sv
// -----------------------------------------------------------------------------
// tb_p_wqe_ring_ctrl
// Bench for p_wqe_ring_ctrl with a 4-deep ring and a behavioural dual-port
// SRAM (registered read address, combinational data out). Accepted writes are
// queued as expected words; every consumer pop is compared against the queue
// head, and count is compared each cycle against the number of queued words.
// -----------------------------------------------------------------------------
module tb_p_wqe_ring_ctrl;

    localparam int unsigned WA = 2;
    localparam int unsigned WD = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          wr_vld;
    logic [WD-1:0] wr_data;
    logic          wr_rdy;
    logic          rd_vld;
    logic [WD-1:0] rd_data;
    logic          rd_rdy;
    logic [WA+1:0] count;
    logic [WA-1:0] mem_addra;
    logic [WD-1:0] mem_dina;
    logic          mem_wena;
    logic [WA-1:0] mem_addrb;
    logic          mem_renb;
    logic [WD-1:0] mem_doutb;

    p_wqe_ring_ctrl #(
        .WIDTH_ADDR (WA),
        .WIDTH_DATA (WD)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .wr_vld    (wr_vld),
        .wr_data   (wr_data),
        .wr_rdy    (wr_rdy),
        .rd_vld    (rd_vld),
        .rd_data   (rd_data),
        .rd_rdy    (rd_rdy),
        .count     (count),
        .mem_addra (mem_addra),
        .mem_dina  (mem_dina),
        .mem_wena  (mem_wena),
        .mem_addrb (mem_addrb),
        .mem_renb  (mem_renb),
        .mem_doutb (mem_doutb)
    );

    always #5 clk = ~clk;

    // Dual-port SRAM: write on port a, 1-cycle read on port b.
    logic [WD-1:0] sram [4];
    logic [WA-1:0] sram_raddr = '0;
    always @(posedge clk) begin
        if (mem_wena) sram[mem_addra] <= mem_dina;
        if (mem_renb) sram_raddr <= mem_addrb;
    end
    assign mem_doutb = sram[sram_raddr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard
    logic [WD-1:0] exp_q[$];
    bit            mon_en = 1'b0;
    int            n_pop  = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk_eq("count", count, exp_q.size());
            if (rst || flush) begin
                exp_q.delete();
            end else begin
                if (exp_q.size() == 0) begin
                    chk_eq("idle_rd_vld", rd_vld, 0);
                end else if (rd_vld && rd_rdy) begin
                    chk_eq("rd_data", rd_data, exp_q.pop_front());
                    n_pop++;
                end
                if (wr_vld && wr_rdy) exp_q.push_back(wr_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Single write into a cleared ring: renb at +1, rd_vld/data at +3.
    task automatic lat_write(input string tag, input logic [WD-1:0] d);
        step(); wr_vld = 1'b1; wr_data = d; rd_rdy = 1'b1;
        sample();
        chk_eq({tag, "_acc"},   wr_rdy, 1);
        chk_eq({tag, "_wena"},  mem_wena, 1);
        chk_eq({tag, "_addra"}, mem_addra, 0);
        chk_eq({tag, "_dina"},  mem_dina, d);
        step(); wr_vld = 1'b0;
        sample();
        chk_eq({tag, "_renb"},  mem_renb, 1);
        chk_eq({tag, "_addrb"}, mem_addrb, 0);
        chk_eq({tag, "_cnt1"},  count, 1);
        step(); sample();
        chk_eq({tag, "_vld2"},  rd_vld, 0);
        chk_eq({tag, "_cnt2"},  count, 1);
        step(); sample();
        chk_eq({tag, "_vld3"},  rd_vld, 1);
        chk_eq({tag, "_data3"}, rd_data, d);
        chk_eq({tag, "_cnt3"},  count, 1);
        step(); sample();
        chk_eq({tag, "_cnt4"},  count, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacc;
        int base;
        int k;
        int first;
        int last;
        int nv;

        rst = 1'b1; flush = 1'b0; wr_vld = 1'b0; wr_data = '0; rd_rdy = 1'b0;
        repeat (2) step();
        sample();
        chk_eq("rst_rd_vld", rd_vld, 0);
        chk_eq("rst_wena",   mem_wena, 0);
        chk_eq("rst_renb",   mem_renb, 0);
        chk_eq("rst_count",  count, 0);
        step(); rst = 1'b0; mon_en = 1'b1;
        sample();
        chk_eq("post_rst_wr_rdy", wr_rdy, 1);
        chk_eq("post_rst_rd_vld", rd_vld, 0);
        chk_eq("post_rst_wena",   mem_wena, 0);
        chk_eq("post_rst_renb",   mem_renb, 0);

        // Single write latency
        lat_write("t028", 8'h5A);

        // Fill to capacity with consumer stalled, then drain in order
        rd_rdy = 1'b0;
        nacc = 0;
        for (int c = 0; c < 30 && nacc < 6; c++) begin
            step(); wr_vld = 1'b1; wr_data = 8'(nacc + 1);
            sample();
            if (wr_rdy) nacc++;
        end
        chk_eq("t029_accepted", nacc, 6);
        step(); wr_vld = 1'b0;
        sample();
        chk_eq("t029_full_wr_rdy", wr_rdy, 0);
        chk_eq("t029_count6", count, 6);
        for (int c = 0; c < 3; c++) begin
            step(); sample();
            chk_eq("t029_hold_vld",  rd_vld, 1);
            chk_eq("t029_hold_data", rd_data, 1);
        end
        step(); rd_rdy = 1'b1; base = n_pop;
        sample();
        for (k = 0; k < 30; k++) begin
            if (count == 0) break;
            step(); sample();
        end
        chk_eq("t029_drained", n_pop - base, 6);
        chk_eq("t029_count0", count, 0);

        // Streaming with both sides held high
        first = -1; last = -1; nv = 0;
        for (int c = 0; c < 40; c++) begin
            step(); wr_vld = (c < 20); wr_data = 8'(8'h30 + c);
            sample();
            if (c < 20) chk_eq("t030_wr_rdy", wr_rdy, 1);
            if (rd_vld) begin
                if (first < 0) first = c;
                last = c;
                nv++;
            end
        end
        chk_eq("t030_first_vld", first, 3);
        chk_eq("t030_n_vld", nv, 20);
        chk_eq("t030_span", last - first, 19);

        // Flush with one word buffered, one in flight and a write attempted
        step(); rd_rdy = 1'b0; wr_vld = 1'b1; wr_data = 8'h71;
        sample();
        step(); wr_data = 8'h72;
        sample();
        step(); wr_vld = 1'b0;
        sample();
        chk_eq("t031_pre_count", count, 2);
        step(); flush = 1'b1; wr_vld = 1'b1; wr_data = 8'hEE;
        sample();
        chk_eq("t031_flush_wr_rdy", wr_rdy, 0);
        chk_eq("t031_flush_wena",   mem_wena, 0);
        chk_eq("t031_pre_vld",      rd_vld, 1);
        step(); flush = 1'b0; wr_vld = 1'b0; rd_rdy = 1'b1;
        sample();
        chk_eq("t031_count0", count, 0);
        chk_eq("t031_rd_vld0", rd_vld, 0);
        for (int c = 0; c < 4; c++) begin
            step(); sample();
            chk_eq("t031_no_stale", rd_vld, 0);
        end
        lat_write("t031_post", 8'h3C);

        // Reset mid-stream at count=4
        rd_rdy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step(); wr_vld = 1'b1; wr_data = 8'(8'h41 + c);
            sample();
            chk_eq("t032_acc", wr_rdy, 1);
        end
        step(); wr_vld = 1'b0;
        sample();
        chk_eq("t032_count4", count, 4);
        step(); rst = 1'b1;
        sample();
        chk_eq("t032_in_rst_vld",  rd_vld, 0);
        chk_eq("t032_in_rst_wena", mem_wena, 0);
        chk_eq("t032_in_rst_renb", mem_renb, 0);
        step(); rst = 1'b0;
        sample();
        chk_eq("t032_rd_vld",  rd_vld, 0);
        chk_eq("t032_wena",    mem_wena, 0);
        chk_eq("t032_renb",    mem_renb, 0);
        chk_eq("t032_wr_rdy",  wr_rdy, 1);
        chk_eq("t032_count0",  count, 0);
        lat_write("t032_post", 8'hA3);

        repeat (3) begin step(); sample(); end
        chk_eq("end_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
